// File: rtl/ngx_http_parse_time_udiv_30ns_14ns_16_seq_pkg.sv
// Shared definitions for the time-field divider: FSM states, operand widths,
// iteration count and the saturation values driven on overflow.
package ngx_http_parse_time_udiv_30ns_14ns_16_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIN0_W = 30;
  localparam int DIN1_W = 14;
  localparam int DOUT_W = 16;
  localparam int ITERS  = DOUT_W;

  localparam logic [DOUT_W-1:0] QUOT_SAT = 16'hFFFF;
  localparam logic [DIN1_W-1:0] REM_SAT  = 14'd0;

endpackage

// File: rtl/ngx_http_parse_time_udiv_step.sv
// One restoring-division step: shift in one dividend bit, subtract the divisor
// if it fits, and report the resulting quotient bit.
module ngx_http_parse_time_udiv_step #(
  parameter int R_W = 14
) (
  input  logic [R_W:0]   t,
  input  logic [R_W-1:0] divisor,
  output logic [R_W-1:0] r_next,
  output logic           qbit
);

  logic [R_W:0] diff;

  // t is {running remainder, next dividend bit}; keep the difference only when non-negative
  always_comb begin
    diff   = t - {1'b0, divisor};
    qbit   = (t >= {1'b0, divisor});
    r_next = qbit ? diff[R_W-1:0] : t[R_W-1:0];
  end

endmodule

// File: rtl/ngx_http_parse_time_udiv_30ns_14ns_16_seq.sv
// Sequential radix-2 restoring divider, 30b / 14b -> 16b quotient + 14b remainder.
// Fixed latency: accept edge, 16 iteration edges, then DONE for one ce cycle.
// Overflow (zero divisor or quotient wider than 16b) is decided from the raw
// operands at accept time and saturates the results.
module ngx_http_parse_time_udiv_30ns_14ns_16_seq
  import ngx_http_parse_time_udiv_30ns_14ns_16_seq_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(dout_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(dout_WIDTH - 1);

  // ID is an instance tag only
  if (ID < 0) begin : g_id_tag
  end

  div_state_e              state, state_d;
  logic                    accept;
  logic [CNT_W-1:0]        cnt;
  logic [din1_WIDTH-1:0]   r, divisor, r_next;
  logic [dout_WIDTH-1:0]   shreg;
  logic                    ovf_q, qbit;

  ngx_http_parse_time_udiv_step #(.R_W(din1_WIDTH)) u_step (
    .t       ({r, shreg[dout_WIDTH-1]}),
    .divisor (divisor),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  // State register; ce=0 freezes the FSM
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)  state <= ST_IDLE;
    else if (ce) state <= state_d;
  end

  // Next state, handshake decode; start is ignored while calculating
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    ready   = (state == ST_IDLE) || (state == ST_DONE);
    done    = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: if (cnt == CNT_LAST) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers loaded on DONE entry
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt     <= '0;
      r       <= '0;
      shreg   <= '0;
      divisor <= '0;
      ovf_q   <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        cnt     <= '0;
        r       <= din0[din0_WIDTH-1:dout_WIDTH];
        shreg   <= din0[dout_WIDTH-1:0];
        divisor <= din1;
        ovf_q   <= (din1 == '0) || (din0[din0_WIDTH-1:dout_WIDTH] >= din1);
      end else if (state == ST_CALC) begin
        r     <= r_next;
        shreg <= {shreg[dout_WIDTH-2:0], qbit};
        cnt   <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          ovf  <= ovf_q;
          quot <= ovf_q ? QUOT_SAT : {shreg[dout_WIDTH-2:0], qbit};
          rem  <= ovf_q ? REM_SAT  : r_next;
        end
      end
    end
  end

endmodule
